// File: rtl/ceyloniac_param_sync_ram.sv
// Parameterised synchronous RAM: byte-masked read/write port A, read-only port B,
// self-clearing sweep after reset or on request, range checking on both ports.
module ceyloniac_param_sync_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ram_enable,
    input  logic                    ram_clear_req,
    input  logic [ADDR_WIDTH-1:0]   ram_a_addr,
    input  logic [DATA_WIDTH-1:0]   ram_a_write_data,
    input  logic [DATA_WIDTH/8-1:0] ram_a_byte_en,
    input  logic                    ram_a_write_enable,
    input  logic                    ram_a_read_enable,
    output logic [DATA_WIDTH-1:0]   ram_a_read_data,
    output logic                    ram_a_read_valid,
    input  logic [ADDR_WIDTH-1:0]   ram_b_addr,
    input  logic                    ram_b_read_enable,
    output logic [DATA_WIDTH-1:0]   ram_b_read_data,
    output logic                    ram_b_read_valid,
    output logic                    ram_busy,
    output logic                    ram_addr_err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
    logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
    logic                  a_vld_q, a_vld_d;
    logic                  b_vld_q, b_vld_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      a_idx, b_idx;
    logic                  acc, a_oob, b_oob, a_rd, b_rd, a_wr, clr_we;
    logic [DATA_WIDTH-1:0] a_old, b_old, b_fwd;

    assign a_idx = ram_a_addr[IDX_W-1:0];
    assign b_idx = ram_b_addr[IDX_W-1:0];

    always_comb begin
        acc    = (state_q == ST_READY) && ram_enable && !rst;
        clr_we = (state_q == ST_CLEAR) && !rst;
        a_oob  = {1'b0, ram_a_addr} >= DEPTH_EXT;
        b_oob  = {1'b0, ram_b_addr} >= DEPTH_EXT;
        a_rd   = acc && ram_a_read_enable;
        b_rd   = acc && ram_b_read_enable;
        a_wr   = acc && ram_a_write_enable && !a_oob;
        a_old  = a_oob ? '0 : mem[a_idx];
        b_old  = b_oob ? '0 : mem[b_idx];
        // Port B sees the word as it will be after this edge's port A write.
        b_fwd  = b_old;
        for (int i = 0; i < NB; i++) begin
            if (a_wr && !b_oob && (a_idx == b_idx) && ram_a_byte_en[i])
                b_fwd[8*i +: 8] = ram_a_write_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                if (ram_clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
        busy_d   = (state_d == ST_CLEAR);
        a_data_d = a_rd ? a_old : a_data_q;
        b_data_d = b_rd ? b_fwd : b_data_q;
        a_vld_d  = a_rd;
        b_vld_d  = b_rd;
        err_d    = acc && ((a_oob && (ram_a_read_enable || ram_a_write_enable)) ||
                           (b_oob && ram_b_read_enable));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            busy_q   <= 1'b1;
            a_data_q <= '0;
            b_data_q <= '0;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
            a_vld_q  <= a_vld_d;
            b_vld_q  <= b_vld_d;
            err_q    <= err_d;
        end
    end

    // Array has no reset; the enables above are already masked while rst is high.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr_q] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (ram_a_byte_en[i])
                    mem[a_idx][8*i +: 8] <= ram_a_write_data[8*i +: 8];
            end
        end
    end

    assign ram_a_read_data  = a_data_q;
    assign ram_a_read_valid = a_vld_q;
    assign ram_b_read_data  = b_data_q;
    assign ram_b_read_valid = b_vld_q;
    assign ram_busy         = busy_q;
    assign ram_addr_err     = err_q;

endmodule
